// File: rtl/ir_packet_tx.sv
// IR car-control packet transmitter: start burst, gap, car-select burst, gap,
// then one carrier burst plus gap per command bit, bit 0 first.
//
// state | meaning
// IDLE  | waiting for SEND_PACKET; COMMAND latched on acceptance
// ARM   | packet accepted, waiting for the carrier phase to wrap
// SEND  | walking the burst/gap segments, one period count per carrier wrap
module ir_packet_tx #(
   parameter int CARRIER_DIV    = 2500,
   parameter int START_BURST    = 88,
   parameter int SELECT_BURST   = 22,
   parameter int GAP            = 40,
   parameter int ASSERT_BURST   = 44,
   parameter int DEASSERT_BURST = 22,
   parameter int NUM_CMD        = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               SEND_PACKET,
   input  logic [NUM_CMD-1:0] COMMAND,
   output logic               BUSY,
   output logic               DONE,
   output logic               IR_LED
);

   localparam int PC_W     = $clog2(CARRIER_DIV);
   localparam int LAST_SEG = 3 + 2 * NUM_CMD;
   localparam int SEG_W    = $clog2(LAST_SEG + 1);
   localparam int MAX_A    = (START_BURST > SELECT_BURST) ? START_BURST : SELECT_BURST;
   localparam int MAX_B    = (ASSERT_BURST > DEASSERT_BURST) ? ASSERT_BURST : DEASSERT_BURST;
   localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_LEN  = (MAX_C > GAP) ? MAX_C : GAP;
   localparam int LEN_W    = $clog2(MAX_LEN) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   state_t             r_state;
   logic [PC_W-1:0]    r_pc;
   logic [SEG_W-1:0]   r_seg;
   logic [LEN_W-1:0]   r_per;
   logic [NUM_CMD-1:0] r_cmd;

   logic               w_pc_wrap;
   logic               w_carrier;
   logic [SEG_W-1:0]   w_bit_off;
   logic               w_bit_val;
   logic [LEN_W-1:0]   w_seg_last;

   assign w_pc_wrap = (r_pc == PC_W'(CARRIER_DIV - 1));
   assign w_carrier = (r_pc < PC_W'(CARRIER_DIV / 2));

   // Command bit i is carried by burst segment 4+2i.
   assign w_bit_off = (r_seg - SEG_W'(4)) >> 1;

   always_comb begin
      w_bit_val = 1'b0;
      for (int i = 0; i < NUM_CMD; i++) begin
         if (w_bit_off == SEG_W'(i)) begin
            w_bit_val = r_cmd[i];
         end
      end
   end

   always_comb begin
      w_seg_last = LEN_W'(GAP - 1);
      if (!r_seg[0]) begin
         if (r_seg == SEG_W'(0)) begin
            w_seg_last = LEN_W'(START_BURST - 1);
         end else if (r_seg == SEG_W'(2)) begin
            w_seg_last = LEN_W'(SELECT_BURST - 1);
         end else if (w_bit_val) begin
            w_seg_last = LEN_W'(ASSERT_BURST - 1);
         end else begin
            w_seg_last = LEN_W'(DEASSERT_BURST - 1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_seg   <= '0;
         r_per   <= '0;
         r_cmd   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         IR_LED  <= 1'b0;
      end else begin
         r_pc   <= w_pc_wrap ? '0 : r_pc + PC_W'(1);
         DONE   <= 1'b0;
         IR_LED <= (r_state == ST_SEND) && !r_seg[0] && w_carrier;

         case (r_state)
            ST_IDLE: begin
               if (SEND_PACKET) begin
                  r_cmd   <= COMMAND;
                  r_seg   <= '0;
                  r_per   <= '0;
                  r_state <= ST_ARM;
                  BUSY    <= 1'b1;
               end
            end

            // Waiting for the wrap makes segment 0 start exactly at pc == 0.
            ST_ARM: begin
               if (w_pc_wrap) begin
                  r_seg   <= '0;
                  r_per   <= '0;
                  r_state <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (w_pc_wrap) begin
                  if (r_per == w_seg_last) begin
                     r_per <= '0;
                     if (r_seg == SEG_W'(LAST_SEG)) begin
                        r_seg   <= '0;
                        r_state <= ST_IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                     end else begin
                        r_seg <= r_seg + SEG_W'(1);
                     end
                  end else begin
                     r_per <= r_per + LEN_W'(1);
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_packet_tx.sv
// Bench for ir_packet_tx: a fast-carrier instance checked burst by burst
// against a queue of expected pulse counts, plus a default-parameter instance.
module tb_ir_packet_tx;

   localparam int CD     = 4;
   localparam int NCMD   = 4;
   localparam int START  = 88;
   localparam int SELECT = 22;
   localparam int GAPP   = 40;
   localparam int ASRT   = 44;
   localparam int DASRT  = 22;
   localparam int GAP_LOW = GAPP * CD + CD / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       send = 1'b0;
   logic [3:0] cmd = 4'd0;
   logic       busy, done, led;

   logic       send_b = 1'b0;
   logic [5:0] cmd_b = 6'd0;
   logic       busy_b, done_b, led_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int q_exp_burst[$];
   int q_exp_gap[$];
   int q_obs_burst[$];
   int q_obs_gap[$];

   int lo_run = 0, hi_run = 0, pcnt = 0, bad_width = 0;
   int n_done = 0, t_first = 0, t_done = 0;
   bit in_burst = 0, prev = 0;

   ir_packet_tx #(.CARRIER_DIV(CD)) dut (
      .CLK(clk), .RESET(rst), .SEND_PACKET(send), .COMMAND(cmd),
      .BUSY(busy), .DONE(done), .IR_LED(led)
   );

   ir_packet_tx #(.NUM_CMD(6)) dut_b (
      .CLK(clk), .RESET(rst), .SEND_PACKET(send_b), .COMMAND(cmd_b),
      .BUSY(busy_b), .DONE(done_b), .IR_LED(led_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Burst is a run of pulses spaced CD/2 apart; any longer low run is a gap.
   always @(negedge clk) begin
      if (rst) begin
         in_burst = 0; prev = 0; lo_run = 0; hi_run = 0; pcnt = 0;
      end else begin
         if (led) begin
            if (!prev) begin
               if (in_burst && lo_run == CD / 2) pcnt++;
               else begin
                  if (in_burst) begin
                     q_obs_burst.push_back(pcnt);
                     q_obs_gap.push_back(lo_run);
                  end else t_first = cyc;
                  pcnt = 1; in_burst = 1;
               end
               hi_run = 0;
            end
            hi_run++; lo_run = 0;
         end else begin
            if (prev && hi_run != CD / 2) bad_width++;
            lo_run++;
         end
         if (done) begin
            n_done++; t_done = cyc;
            if (in_burst) begin
               q_obs_burst.push_back(pcnt);
               q_obs_gap.push_back(lo_run);
            end
            in_burst = 0;
         end
         prev = led;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_packet(input logic [3:0] c, output int total);
      q_exp_burst.push_back(START);
      q_exp_burst.push_back(SELECT);
      total = START + SELECT + GAPP * (2 + NCMD);
      for (int i = 0; i < NCMD; i++) begin
         q_exp_burst.push_back(c[i] ? ASRT : DASRT);
         total += c[i] ? ASRT : DASRT;
      end
      for (int i = 0; i < 2 + NCMD; i++) q_exp_gap.push_back(GAP_LOW);
   endtask

   task automatic request(input logic [3:0] c);
      @(posedge clk); #1; cmd = c; send = 1'b1;
      @(negedge clk); chk("busy_before_accept", busy, 1'b0);
      @(posedge clk); #1; send = 1'b0;
      @(negedge clk); chk("busy_after_accept", busy, 1'b1);
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (!done && k < max_cyc);
      #1;
      chk({tag, "_done_seen"}, done, 1'b1);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
   endtask

   task automatic wait_bursts(input string tag, input int n);
      int k;
      k = 0;
      while (q_obs_burst.size() < n && k < 4000) begin @(negedge clk); k++; end
      #1;
      chk({tag, "_reached_burst"}, (q_obs_burst.size() >= n), 1'b1);
   endtask

   task automatic compare_packet(input string tag, input int total);
      int e, o;
      chk({tag, "_nbursts"}, q_obs_burst.size(), 2 + NCMD);
      chk({tag, "_ngaps"}, q_obs_gap.size(), 2 + NCMD);
      for (int i = 0; i < 2 + NCMD; i++) begin
         e = q_exp_burst.pop_front();
         o = (q_obs_burst.size() > 0) ? q_obs_burst.pop_front() : -1;
         chk($sformatf("%s_burst%0d", tag, i), o, e);
      end
      for (int i = 0; i < 2 + NCMD; i++) begin
         e = q_exp_gap.pop_front();
         o = (q_obs_gap.size() > 0) ? q_obs_gap.pop_front() : -1;
         chk($sformatf("%s_gap%0d", tag, i), o, e);
      end
      chk({tag, "_duration"}, t_done - t_first, total * CD - 1);
      chk({tag, "_pulse_width"}, bad_width, 0);
   endtask

   initial begin
      int tot, nd, k, hi, lo;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_led", led, 1'b0);
      chk("rst_led_b", led_b, 1'b0);
      @(posedge clk); #1; rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_led", led, 1'b0);
      chk("idle_busy", busy, 1'b0);

      // all-zero command
      request(4'b0000);
      push_packet(4'b0000, tot);
      wait_done("c1", 3000);
      compare_packet("c1", tot);

      // mixed bits, order-sensitive
      request(4'b1011);
      push_packet(4'b1011, tot);
      wait_done("c2", 3000);
      compare_packet("c2", tot);

      // COMMAND change and extra request during the select burst
      request(4'b0110);
      push_packet(4'b0110, tot);
      wait_bursts("c3", 1);
      repeat (20) @(posedge clk);
      #1; cmd = 4'b1001; send = 1'b1;
      repeat (5) @(posedge clk);
      #1; send = 1'b0;
      wait_done("c3", 3000);
      compare_packet("c3", tot);
      nd = n_done;
      repeat (40) @(negedge clk);
      chk("c3_no_second_busy", busy, 1'b0);
      chk("c3_no_second_done", n_done, nd);

      // back-to-back with SEND_PACKET held high
      @(posedge clk); #1; cmd = 4'b0011; send = 1'b1;
      push_packet(4'b0011, tot);
      @(posedge clk); #1; cmd = 4'b1100;
      wait_done("b2b1", 3000);
      compare_packet("b2b1", tot);
      @(negedge clk);
      chk("b2b_rearm_busy", busy, 1'b1);
      chk("b2b_rearm_done", done, 1'b0);
      #1; send = 1'b0;
      push_packet(4'b1100, tot);
      wait_done("b2b2", 3000);
      compare_packet("b2b2", tot);

      // reset inside segment 6
      request(4'b0101);
      wait_bursts("rst6", 3);
      repeat (3) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst6_led", led, 1'b0);
      chk("rst6_busy", busy, 1'b0);
      chk("rst6_done", done, 1'b0);
      q_exp_burst.delete(); q_exp_gap.delete();
      q_obs_burst.delete(); q_obs_gap.delete();
      bad_width = 0;
      nd = n_done;
      repeat (300) @(negedge clk);
      chk("rst6_no_done", n_done, nd);
      chk("rst6_idle_busy", busy, 1'b0);
      request(4'b0101);
      push_packet(4'b0101, tot);
      wait_done("rst6_after", 3000);
      compare_packet("rst6_after", tot);

      // default carrier on the 6-bit instance
      @(posedge clk); #1; cmd_b = 6'b000001; send_b = 1'b1;
      @(posedge clk); #1; send_b = 1'b0;
      @(negedge clk);
      chk("b_busy", busy_b, 1'b1);
      k = 0;
      while (!led_b && k < 3000) begin @(negedge clk); k++; end
      chk("b_first_rise", led_b, 1'b1);
      hi = 0;
      while (led_b && hi < 3000) begin @(negedge clk); hi++; end
      chk("b_high1", hi, 1250);
      lo = 0;
      while (!led_b && lo < 3000) begin @(negedge clk); lo++; end
      chk("b_low1", lo, 1250);
      hi = 0;
      while (led_b && hi < 3000) begin @(negedge clk); hi++; end
      chk("b_high2", hi, 1250);
      chk("b_still_busy", busy_b, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
